full_adder_core: RTL and testbench
==================================

Name: full_adder_core

Overview:
- Parameterised ripple-carry full adder: sums operands X_i and B_i with carry-in C_i.
- Provides a zero-latency combinational result plus a one-cycle registered copy with a valid strobe.
- Used as the arithmetic leaf cell in datapaths; the WIDTH=1 instance is the classic 1-bit full adder.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk_i  input  1  single clock; all registers update on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- X_i  input  WIDTH  operand A.
- B_i  input  WIDTH  operand B.
- C_i  input  1  carry-in.
- vld_i  input  1  qualifies X_i/B_i/C_i for capture into the registered stage.
- S_o  output  WIDTH  combinational sum, (X_i + B_i + C_i) mod 2^WIDTH.
- C_o  output  1  combinational carry-out, bit WIDTH of X_i + B_i + C_i.
- S_q_o  output  WIDTH  registered sum.
- C_q_o  output  1  registered carry-out.
- vld_o  output  1  registered valid; high one cycle after an accepted vld_i.

Behaviour:
- Combinational path:
  - {C_o, S_o} = X_i + B_i + C_i, computed at WIDTH+1 bits.
  - Zero latency, purely a function of X_i/B_i/C_i.
  - Must not depend on clk_i or rst_i; must be correct with the clock idle and rst_i undriven.
- Bit-level structure, stage k:
  - s[k] = x[k] XOR b[k] XOR c[k].
  - c[k+1] = (x[k] AND b[k]) OR (c[k] AND (x[k] XOR b[k])).
  - c[0] = C_i; C_o = c[WIDTH].
- WIDTH=1 truth table {C_o,S_o} for X,B,C:
  - 000→00, 001→01, 010→01, 011→10.
  - 100→01, 101→10, 110→10, 111→11.
- Registered path, one cycle latency:
  - On a clock edge with rst_i=1: S_q_o=0, C_q_o=0, vld_o=0 (reset wins over vld_i).
  - Edge with rst_i=0 and vld_i=1: S_q_o←S_o, C_q_o←C_o, vld_o←1.
  - Edge with rst_i=0 and vld_i=0: S_q_o/C_q_o hold their value; vld_o←0.
- Wrap-around: all-ones + all-ones + 1 gives S_o all-ones and C_o=1; no saturation.
- X/Z on inputs may propagate to the combinational outputs; registers never see X after reset unless vld_i captures X.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined:
  - Adds output V_o (1 bit, combinational) = c[WIDTH] XOR c[WIDTH-1], the two's-complement signed overflow.
  - Adds registered V_q_o, reset 0, captured under the same rules as C_q_o.
  - For WIDTH=1, c[WIDTH-1] = C_i.
- Undefined: V_o and V_q_o do not exist; all other behaviour is identical.

Test Plan:
- WIDTH=1, clock idle, apply all 8 X/B/C combinations with 10 time units each → S_o/C_o match the truth table exactly (!== compare).
- WIDTH=8: X=0xFF, B=0x01, C=0 → S_o=0x00, C_o=1; X=0x7F, B=0x00, C=1 → S_o=0x80, C_o=0 (V_o=1 when FULL_ADDER_OVF_EN is defined).
- Registered path: vld_i=1 with X=3, B=5, C=1 (WIDTH=4) at edge N → at edge N+1 S_q_o=9, C_q_o=0, vld_o=1; vld_i=0 at the next edge → vld_o=0, S_q_o holds 9.
- Reset: rst_i=1 together with vld_i=1 → after the edge S_q_o=0, C_q_o=0, vld_o=0; the combinational S_o still shows the live sum.
- Reset mid-stream: stream of vld_i=1 operands, assert rst_i for one cycle → registers clear that cycle and resume capturing on the first edge after rst_i falls.

Source files
------------

// File: rtl/full_adder_core.sv
// Parameterised ripple-carry full adder with a combinational result and a one-cycle registered copy.
// Optional signed-overflow outputs V_o/V_q_o are built when FULL_ADDER_OVF_EN is defined.
module full_adder_core #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] X_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic [WIDTH-1:0] S_q_o,
  output logic             C_q_o,
  output logic             vld_o
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             V_o,
  output logic             V_q_o
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Explicit per-bit ripple chain; carry[0] is the carry-in, carry[WIDTH] the carry-out.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = C_i;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      sum[k]     = X_i[k] ^ B_i[k] ^ carry[k];
      carry[k+1] = (X_i[k] & B_i[k]) | (carry[k] & (X_i[k] ^ B_i[k]));
    end
  end

  assign S_o = sum;
  assign C_o = carry[WIDTH];

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             vld_d, vld_q;

  always_comb begin
    s_d   = s_q;
    c_d   = c_q;
    vld_d = 1'b0;
    if (vld_i) begin
      s_d   = sum;
      c_d   = carry[WIDTH];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

  assign S_q_o = s_q;
  assign C_q_o = c_q;
  assign vld_o = vld_q;

`ifdef FULL_ADDER_OVF_EN
  logic v_d, v_q;

  // For WIDTH=1 carry[WIDTH-1] is the carry-in itself.
  assign V_o = carry[WIDTH] ^ carry[WIDTH-1];

  always_comb begin
    v_d = v_q;
    if (vld_i) v_d = V_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign V_q_o = v_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH=1, 4 and 8 against an arithmetic reference model.
// Optional overflow outputs are checked when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_core;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  bit   run_clk = 1'b0;
  logic rst;

  always #5 if (run_clk) clk = ~clk;

  logic       x1, b1, c1, vi1, s1, co1, sq1, cq1, vo1, v1, vq1;
  logic [3:0] x4, b4, s4, sq4;
  logic       c4, vi4, co4, cq4, vo4, v4, vq4;
  logic [7:0] x8, b8, s8, sq8;
  logic       c8, vi8, co8, cq8, vo8, v8, vq8;

  full_adder_core #(.WIDTH(1)) u1 (
    .clk_i(clk), .rst_i(rst), .X_i(x1), .B_i(b1), .C_i(c1), .vld_i(vi1),
    .S_o(s1), .C_o(co1), .S_q_o(sq1), .C_q_o(cq1), .vld_o(vo1)
`ifdef FULL_ADDER_OVF_EN
    , .V_o(v1), .V_q_o(vq1)
`endif
  );

  full_adder_core #(.WIDTH(4)) u4 (
    .clk_i(clk), .rst_i(rst), .X_i(x4), .B_i(b4), .C_i(c4), .vld_i(vi4),
    .S_o(s4), .C_o(co4), .S_q_o(sq4), .C_q_o(cq4), .vld_o(vo4)
`ifdef FULL_ADDER_OVF_EN
    , .V_o(v4), .V_q_o(vq4)
`endif
  );

  full_adder_core #(.WIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst), .X_i(x8), .B_i(b8), .C_i(c8), .vld_i(vi8),
    .S_o(s8), .C_o(co8), .S_q_o(sq8), .C_q_o(cq8), .vld_o(vo8)
`ifdef FULL_ADDER_OVF_EN
    , .V_o(v8), .V_q_o(vq8)
`endif
  );

  // Signed overflow from the value range of the true signed sum.
  function automatic logic ref_ovf(int w, int x, int b, int c);
    int sx, sb, r;
    sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sx + sb + c;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  task automatic test_comb_truth();
    logic [1:0] tt [8];
    logic [2:0] idx;
    int sum;
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      x1 = idx[2]; b1 = idx[1]; c1 = idx[0];
      #10;
      sum = int'(x1) + int'(b1) + int'(c1);
      total++;
      if ({co1, s1} !== tt[i]) begin
        bad++;
        $display("FAIL truth_table xbc=%b got=%b exp=%b", idx, {co1, s1}, tt[i]);
      end
      total++;
      if ({co1, s1} !== 2'(sum)) begin
        bad++;
        $display("FAIL truth_model xbc=%b got=%b exp=%b", idx, {co1, s1}, 2'(sum));
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if (v1 !== ref_ovf(1, int'(x1), int'(b1), int'(c1))) begin
        bad++;
        $display("FAIL truth_ovf xbc=%b got=%b", idx, v1);
      end
`endif
    end
  endtask

  task automatic test_boundary_w8();
    x8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    #10;
    total++;
    if ({co8, s8} !== 9'h100) begin
      bad++;
      $display("FAIL w8_wrap got=%h exp=100", {co8, s8});
    end
`ifdef FULL_ADDER_OVF_EN
    total++;
    if (v8 !== 1'b0) begin bad++; $display("FAIL w8_wrap_ovf got=%b exp=0", v8); end
`endif
    x8 = 8'h7F; b8 = 8'h00; c8 = 1'b1;
    #10;
    total++;
    if ({co8, s8} !== 9'h080) begin
      bad++;
      $display("FAIL w8_signflip got=%h exp=080", {co8, s8});
    end
`ifdef FULL_ADDER_OVF_EN
    total++;
    if (v8 !== 1'b1) begin bad++; $display("FAIL w8_signflip_ovf got=%b exp=1", v8); end
`endif
    x8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    #10;
    total++;
    if ({co8, s8} !== 9'h1FF) begin
      bad++;
      $display("FAIL w8_allones got=%h exp=1ff", {co8, s8});
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    x4 = 4'd3; b4 = 4'd5; c4 = 1'b1; vi4 = 1'b1;
    x8 = 8'hA5; b8 = 8'h3C; c8 = 1'b0; vi8 = 1'b1;
    x1 = 1'b1; b1 = 1'b1; c1 = 1'b1; vi1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cq4, sq4, vo4} !== 6'b0) begin
      bad++;
      $display("FAIL reset_w4 got c=%b s=%h v=%b exp all 0", cq4, sq4, vo4);
    end
    total++;
    if ({cq8, sq8, vo8, cq1, sq1, vo1} !== 13'b0) begin
      bad++;
      $display("FAIL reset_w8_w1 got s8=%h c8=%b v8=%b s1=%b c1=%b v1=%b", sq8, cq8, vo8, sq1, cq1, vo1);
    end
    total++;
    if ({co4, s4} !== 5'd9) begin
      bad++;
      $display("FAIL reset_live_sum got=%h exp=09", {co4, s4});
    end
`ifdef FULL_ADDER_OVF_EN
    total++;
    if ({vq1, vq4, vq8} !== 3'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=000", {vq1, vq4, vq8}); end
`endif
  endtask

  task automatic test_registered();
    rst = 1'b0;
    vi1 = 1'b0; vi8 = 1'b0;
    x4 = 4'd3; b4 = 4'd5; c4 = 1'b1; vi4 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cq4, sq4, vo4} !== {1'b0, 4'd9, 1'b1}) begin
      bad++;
      $display("FAIL reg_capture got c=%b s=%h v=%b exp c=0 s=9 v=1", cq4, sq4, vo4);
    end
    vi4 = 1'b0; x4 = 4'hF; b4 = 4'hE; c4 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cq4, sq4, vo4} !== {1'b0, 4'd9, 1'b0}) begin
      bad++;
      $display("FAIL reg_hold got c=%b s=%h v=%b exp c=0 s=9 v=0", cq4, sq4, vo4);
    end
  endtask

  task automatic test_reset_midstream();
    int sum;
    logic [4:0] exp_cs;
    logic       exp_v;
    for (int n = 0; n < 8; n++) begin
      x4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); vi4 = 1'b1;
      rst = (n == 4);
      sum = int'(x4) + int'(b4) + int'(c4);
      exp_cs = rst ? 5'd0 : 5'(sum);
      exp_v  = !rst;
      @(posedge clk); #1;
      total++;
      if ({cq4, sq4, vo4} !== {exp_cs, exp_v}) begin
        bad++;
        $display("FAIL midstream[%0d] got c=%b s=%h v=%b exp c=%b s=%h v=%b",
                 n, cq4, sq4, vo4, exp_cs[4], exp_cs[3:0], exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int sum1, sum4, sum8;
    logic [1:0] e1;  logic ev1;  logic eo1;
    logic [4:0] e4;  logic ev4;  logic eo4;
    logic [8:0] e8;  logic ev8;  logic eo8;
    rst = 1'b1;
    @(posedge clk); #1;
    e1 = '0; e4 = '0; e8 = '0; ev1 = 0; ev4 = 0; ev8 = 0; eo1 = 0; eo4 = 0; eo8 = 0;
    for (int n = 0; n < 200; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      x1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); vi1 = 1'($urandom);
      x4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); vi4 = 1'($urandom);
      x8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); vi8 = 1'($urandom);
      #1;
      sum1 = int'(x1) + int'(b1) + int'(c1);
      sum4 = int'(x4) + int'(b4) + int'(c4);
      sum8 = int'(x8) + int'(b8) + int'(c8);
      total++;
      if ({co1, s1} !== 2'(sum1) || {co4, s4} !== 5'(sum4) || {co8, s8} !== 9'(sum8)) begin
        bad++;
        $display("FAIL rand_comb[%0d] got w1=%h w4=%h w8=%h exp w1=%h w4=%h w8=%h",
                 n, {co1, s1}, {co4, s4}, {co8, s8}, 2'(sum1), 5'(sum4), 9'(sum8));
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if ({v1, v4, v8} !== {ref_ovf(1, int'(x1), int'(b1), int'(c1)),
                            ref_ovf(4, int'(x4), int'(b4), int'(c4)),
                            ref_ovf(8, int'(x8), int'(b8), int'(c8))}) begin
        bad++;
        $display("FAIL rand_ovf[%0d] got=%b", n, {v1, v4, v8});
      end
`endif
      if (rst) begin
        e1 = '0; e4 = '0; e8 = '0; ev1 = 0; ev4 = 0; ev8 = 0; eo1 = 0; eo4 = 0; eo8 = 0;
      end else begin
        ev1 = vi1; ev4 = vi4; ev8 = vi8;
        if (vi1) begin e1 = 2'(sum1); eo1 = ref_ovf(1, int'(x1), int'(b1), int'(c1)); end
        if (vi4) begin e4 = 5'(sum4); eo4 = ref_ovf(4, int'(x4), int'(b4), int'(c4)); end
        if (vi8) begin e8 = 9'(sum8); eo8 = ref_ovf(8, int'(x8), int'(b8), int'(c8)); end
      end
      @(posedge clk); #1;
      total++;
      if ({cq1, sq1, vo1} !== {e1, ev1} || {cq4, sq4, vo4} !== {e4, ev4} ||
          {cq8, sq8, vo8} !== {e8, ev8}) begin
        bad++;
        $display("FAIL rand_reg[%0d] got w1=%h/%b w4=%h/%b w8=%h/%b exp w1=%h/%b w4=%h/%b w8=%h/%b",
                 n, {cq1, sq1}, vo1, {cq4, sq4}, vo4, {cq8, sq8}, vo8, e1, ev1, e4, ev4, e8, ev8);
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if ({vq1, vq4, vq8} !== {eo1, eo4, eo8}) begin
        bad++;
        $display("FAIL rand_reg_ovf[%0d] got=%b exp=%b", n, {vq1, vq4, vq8}, {eo1, eo4, eo8});
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    x4 = '0; b4 = '0; c4 = 1'b0; vi4 = 1'b0;
    x8 = '0; b8 = '0; c8 = 1'b0; vi8 = 1'b0;
    x1 = 1'b0; b1 = 1'b0; c1 = 1'b0; vi1 = 1'b0;
    test_comb_truth();
    test_boundary_w8();
    run_clk = 1'b1;
    test_reset();
    test_registered();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
